// File: rtl/param_fifo.sv
// param_fifo: single-clock synchronous FIFO with a registered read port.
// Pointers carry an extra wrap bit, so full and empty can be told apart
// without a separate occupancy counter. The storage array has no reset.
module param_fifo #(
    parameter int FIFO_DEPTH = 8,
    parameter int FIFO_WIDTH = 32,
    parameter int AF_THRESH  = FIFO_DEPTH - 2,
    parameter int AE_THRESH  = 2
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           flush,
    input  logic                           push,
    input  logic                           pop,
    input  logic [FIFO_WIDTH-1:0]          data_in,
    output logic [FIFO_WIDTH-1:0]          data_out,
    output logic                           data_valid,
    output logic                           fifo_full,
    output logic                           fifo_empty,
    output logic                           almost_full,
    output logic                           almost_empty,
    output logic [$clog2(FIFO_DEPTH):0]    fill_count,
    output logic                           overflow,
    output logic                           underflow
);

    localparam int AW = $clog2(FIFO_DEPTH);

    // Thresholds and the pointer step, sized to the pointer width so every
    // compare and add below is width-matched.
    localparam logic [AW:0] AF_LVL  = AF_THRESH[AW:0];
    localparam logic [AW:0] AE_LVL  = AE_THRESH[AW:0];
    localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

    logic [FIFO_WIDTH-1:0] mem [FIFO_DEPTH];
    logic [AW:0]           wr_ptr;
    logic [AW:0]           rd_ptr;
    logic                  push_ok;
    logic                  pop_ok;

    // Acceptance uses the flags as they stand at the start of the cycle.
    // A flush overrides any push or pop in the same cycle.
    assign push_ok = push && !fifo_full  && !flush;
    assign pop_ok  = pop  && !fifo_empty && !flush;

    // Occupancy flags depend only on the registered pointers, so no input
    // reaches an output through combinational logic.
    always_comb begin
        fill_count   = wr_ptr - rd_ptr;
        fifo_empty   = (wr_ptr == rd_ptr);
        fifo_full    = (wr_ptr[AW] != rd_ptr[AW]) &&
                       (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
        almost_full  = (fill_count >= AF_LVL);
        almost_empty = (fill_count <= AE_LVL);
    end

    // Storage write; contents are not cleared by reset or flush.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr[AW-1:0]] <= data_in;
        end
    end

    // Pointers, read register and sticky error flags. A flush does not
    // touch data_out or the sticky flags, and cannot set the error flags.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            data_out   <= '0;
            data_valid <= 1'b0;
            overflow   <= 1'b0;
            underflow  <= 1'b0;
        end else if (flush) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            data_valid <= 1'b0;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + PTR_ONE;
            end
            if (pop_ok) begin
                rd_ptr   <= rd_ptr + PTR_ONE;
                data_out <= mem[rd_ptr[AW-1:0]];
            end
            data_valid <= pop_ok;
            if (push && fifo_full) begin
                overflow <= 1'b1;
            end
            if (pop && fifo_empty) begin
                underflow <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_param_fifo.sv
// tb_param_fifo: directed and randomized checks of param_fifo against a
// queue-based reference model (depth 8, width 16, AF 6, AE 2).
module tb_param_fifo;

    localparam int DEPTH = 8;
    localparam int WIDTH = 16;
    localparam int AF    = 6;
    localparam int AE    = 2;

    logic             clk;
    logic             reset;
    logic             flush;
    logic             push;
    logic             pop;
    logic [WIDTH-1:0] data_in;
    logic [WIDTH-1:0] data_out;
    logic             data_valid;
    logic             fifo_full;
    logic             fifo_empty;
    logic             almost_full;
    logic             almost_empty;
    logic [3:0]       fill_count;
    logic             overflow;
    logic             underflow;

    param_fifo #(
        .FIFO_DEPTH (DEPTH),
        .FIFO_WIDTH (WIDTH),
        .AF_THRESH  (AF),
        .AE_THRESH  (AE)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .flush        (flush),
        .push         (push),
        .pop          (pop),
        .data_in      (data_in),
        .data_out     (data_out),
        .data_valid   (data_valid),
        .fifo_full    (fifo_full),
        .fifo_empty   (fifo_empty),
        .almost_full  (almost_full),
        .almost_empty (almost_empty),
        .fill_count   (fill_count),
        .overflow     (overflow),
        .underflow    (underflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model state
    logic [WIDTH-1:0] q[$];
    logic [WIDTH-1:0] m_dout;
    logic             m_dv;
    logic             m_ovf;
    logic             m_unf;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        int n;
        n = q.size();
        chk({tag, " fill_count"},   32'(fill_count),   32'(n));
        chk({tag, " fifo_empty"},   32'(fifo_empty),   32'(n == 0));
        chk({tag, " fifo_full"},    32'(fifo_full),    32'(n == DEPTH));
        chk({tag, " almost_full"},  32'(almost_full),  32'(n >= AF));
        chk({tag, " almost_empty"}, 32'(almost_empty), 32'(n <= AE));
        chk({tag, " data_valid"},   32'(data_valid),   32'(m_dv));
        chk({tag, " data_out"},     32'(data_out),     32'(m_dout));
        chk({tag, " overflow"},     32'(overflow),     32'(m_ovf));
        chk({tag, " underflow"},    32'(underflow),    32'(m_unf));
    endtask

    task automatic model_reset();
        q.delete();
        m_dout = '0;
        m_dv   = 1'b0;
        m_ovf  = 1'b0;
        m_unf  = 1'b0;
    endtask

    // Apply one cycle of stimulus, update the model with the pre-edge
    // occupancy, then check all outputs shortly after the edge.
    task automatic step(input string tag, input logic p, input logic r,
                        input logic f, input logic [WIDTH-1:0] d);
        bit was_full;
        bit was_empty;
        push    = p;
        pop     = r;
        flush   = f;
        data_in = d;
        @(posedge clk);
        was_full  = (q.size() == DEPTH);
        was_empty = (q.size() == 0);
        if (f) begin
            q.delete();
            m_dv = 1'b0;
        end else begin
            if (p && was_full)  m_ovf = 1'b1;
            if (r && was_empty) m_unf = 1'b1;
            if (r && !was_empty) begin
                m_dout = q.pop_front();
                m_dv   = 1'b1;
            end else begin
                m_dv = 1'b0;
            end
            if (p && !was_full) q.push_back(d);
        end
        #1;
        push  = 1'b0;
        pop   = 1'b0;
        flush = 1'b0;
        check_all(tag);
    endtask

    task automatic do_reset();
        reset = 1'b0;
        model_reset();
        @(posedge clk);
        #1;
        check_all("reset");
        @(negedge clk);
        reset = 1'b1;
    endtask

    initial begin
        logic [WIDTH-1:0] d;
        reset   = 1'b0;
        flush   = 1'b0;
        push    = 1'b0;
        pop     = 1'b0;
        data_in = '0;
        model_reset();
        #2;
        check_all("async_reset_initial");
        do_reset();

        // Fill 0x0001..0x0008, then overflow attempt
        for (int i = 1; i <= DEPTH; i++) step("fill", 1'b1, 1'b0, 1'b0, 16'(i));
        step("push_on_full", 1'b1, 1'b0, 1'b0, 16'hDEAD);

        // Drain in order, then underflow attempt (data_out holds 0x0008)
        for (int i = 1; i <= DEPTH; i++) step("drain", 1'b0, 1'b1, 1'b0, '0);
        chk("last_word", 32'(data_out), 32'h0008);
        step("pop_on_empty", 1'b0, 1'b1, 1'b0, '0);

        // Clear sticky flags, then steady push+pop at level 4 across wrap
        do_reset();
        d = 16'h0100;
        for (int i = 0; i < 4; i++) begin
            step("prefill4", 1'b1, 1'b0, 1'b0, d);
            d++;
        end
        for (int i = 0; i < 20; i++) begin
            step("pushpop4", 1'b1, 1'b1, 1'b0, d);
            d++;
        end

        // Full FIFO with simultaneous push and pop
        for (int i = 0; i < 4; i++) begin
            step("fill_to_full", 1'b1, 1'b0, 1'b0, d);
            d++;
        end
        step("pushpop_full", 1'b1, 1'b1, 1'b0, 16'hBEEF);
        for (int i = 0; i < 7; i++) step("drain2", 1'b0, 1'b1, 1'b0, '0);

        // Empty FIFO with simultaneous push and pop
        step("pushpop_empty", 1'b1, 1'b1, 1'b0, 16'h1234);

        // Five entries stored, then a one-cycle flush with a push and pop
        for (int i = 0; i < 4; i++) begin
            step("fill5", 1'b1, 1'b0, 1'b0, d);
            d++;
        end
        step("pop_before_flush", 1'b0, 1'b1, 1'b0, '0);
        step("refill5", 1'b1, 1'b0, 1'b0, d);
        step("flush", 1'b1, 1'b1, 1'b1, 16'h5555);
        step("after_flush", 1'b0, 1'b0, 1'b0, '0);

        // Three entries stored, pop pending, reset between edges
        for (int i = 0; i < 3; i++) begin
            step("fill3", 1'b1, 1'b0, 1'b0, d);
            d++;
        end
        pop = 1'b1;
        #2;
        reset = 1'b0;
        model_reset();
        #1;
        check_all("mid_cycle_reset");
        @(posedge clk);
        #1;
        pop = 1'b0;
        check_all("no_dv_after_reset");
        @(negedge clk);
        reset = 1'b1;

        // Randomized traffic with occasional flush
        for (int i = 0; i < 400; i++) begin
            logic p;
            logic r;
            logic f;
            p = ($urandom_range(0, 99) < ((i / 50) % 2 == 0 ? 65 : 35));
            r = ($urandom_range(0, 99) < ((i / 50) % 2 == 0 ? 35 : 65));
            f = ($urandom_range(0, 63) == 0);
            step("random", p, r, f, 16'($urandom));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
